// File: rtl/aes_pkg.sv
// Shared AES definitions: MixColumns FSM states, GF(2^8) constants and multiply helpers.
package aes_pkg;

  localparam int         AES_COLS = 4;
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mix_fsm_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b2;
  endfunction

endpackage

// File: rtl/mix_col_word.sv
// Combinational single-column MixColumns / InvMixColumns transform.
module mix_col_word
  import aes_pkg::*;
(
  input  logic        inverse,
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  // Coefficient index 0..3 selects from the circulant row {2,3,1,1} or {14,11,13,9}.
  function automatic logic [7:0] coef_mul(input logic [1:0] idx, input logic inv,
                                          input logic [7:0] b);
    logic [7:0] res;
    if (!inv) begin
      case (idx)
        2'd0:    res = gf_mul2(b);
        2'd1:    res = gf_mul3(b);
        default: res = b;
      endcase
    end else begin
      case (idx)
        2'd0:    res = gf_mul14(b);
        2'd1:    res = gf_mul11(b);
        2'd2:    res = gf_mul13(b);
        default: res = gf_mul9(b);
      endcase
    end
    return res;
  endfunction

  // NOTE: combinational accumulation uses blocking assignments so each XOR sees the previous partial sum.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < AES_COLS; r++) begin
      for (int k = 0; k < AES_COLS; k++) begin
        col_out[8*r +: 8] = col_out[8*r +: 8] ^ coef_mul(2'(k - r), inverse, col_in[8*k +: 8]);
      end
    end
  end

endmodule

// File: rtl/mix_cols_seq.sv
// Sequential MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Optional MIX_COLS_SEQ_BYPASS_EN adds in_bypass for final-round pass-through blocks.
module mix_cols_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inverse,
`ifdef MIX_COLS_SEQ_BYPASS_EN
  input  logic         in_bypass,
`endif
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NGRP  = 4 / COLS_PER_CYCLE;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $fatal(1, "mix_cols_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mix_fsm_t                      state_q, state_d;
  logic [GRP_W-1:0]              grp_q, grp_d;
  logic                          inv_q, inv_d;
  logic [AES_COLS-1:0][31:0]     work_q, work_d;

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_res [COLS_PER_CYCLE];

  // Column mux: group grp owns columns grp*COLS_PER_CYCLE upward.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign col_idx[j] = 2'(int'(grp_q) * COLS_PER_CYCLE + j);

    mix_col_word u_word (
      .inverse (inv_q),
      .col_in  (work_q[col_idx[j]]),
      .col_out (col_res[j])
    );
  end

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    inv_d   = inv_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          inv_d   = in_inverse;
          grp_d   = '0;
          state_d = BUSY;
`ifdef MIX_COLS_SEQ_BYPASS_EN
          if (in_bypass) state_d = DONE;
`endif
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          work_d[col_idx[j]] = col_res[j];
        end
        if (grp_q == GRP_W'(NGRP - 1)) begin
          grp_d   = '0;
          state_d = DONE;
        end else begin
          grp_d = grp_q + GRP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the work register is reset with the control state so an aborted block leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      inv_q   <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      inv_q   <= inv_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = (state_q == DONE) ? work_q : '0;

endmodule

// File: tb/tb_mix_cols_seq.sv
// Scoreboard bench for mix_cols_seq at COLS_PER_CYCLE = 1, 2 and 4 against a GF(2^8) reference model.
module tb_mix_cols_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] st;
    int           hs;
    int           lat;
  } exp_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pc(input logic [7:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Generic shift-and-add GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1B;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
    end else begin
      cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k - r + 4) % 4], st[8*(4*c+k) +: 8]);
        res[8*(4*c+r) +: 8] = acc;
      end
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int CPC = 1 << gi;
    localparam int NG  = 4 / CPC;

    logic         rst, in_valid, in_ready, in_inverse, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;
`ifdef MIX_COLS_SEQ_BYPASS_EN
    logic         in_bypass;
`endif
    bit           done = 1'b0;
    bit           seen = 1'b0;
    exp_t         q[$];

    mix_cols_seq #(.COLS_PER_CYCLE(CPC)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_inverse (in_inverse),
`ifdef MIX_COLS_SEQ_BYPASS_EN
      .in_bypass  (in_bypass),
`endif
      .in_state   (in_state),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_state  (out_state),
      .busy       (busy)
    );

    function automatic string tag(input string s);
      return $sformatf("cpc%0d_%s", CPC, s);
    endfunction

    // Present a block, wait for acceptance, push its expected result.
    task automatic send(input logic [127:0] st, input logic inv, input logic byp,
                        input logic [127:0] expst, input bit keep, output int hs);
      in_state   = st;
      in_inverse = inv;
`ifdef MIX_COLS_SEQ_BYPASS_EN
      in_bypass  = byp;
`endif
      in_valid   = 1'b1;
      hs = -1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (in_ready) begin
          hs = ncyc + 1;
          break;
        end
      end
      if (hs < 0) begin
        check(tag("accept_timeout"), 0, 1);
        in_valid = 1'b0;
      end else begin
        q.push_back('{st: expst, hs: hs, lat: (byp ? 1 : NG + 1)});
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
      end
    endtask

    task automatic drain();
      for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
      check(tag("drain"), q.size(), 0);
      @(posedge clk);
      #1;
    endtask

    always @(negedge clk) begin
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          check(tag("spurious_valid"), out_valid, 0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check(tag("latency"), ncyc - q[0].hs + 1, q[0].lat);
          end
          check(tag("out_state"), out_state, q[0].st);
          check(tag("in_ready_in_done"), in_ready, 0);
          check(tag("busy_in_done"), busy, 1);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end

    initial begin : stim
      logic [127:0] a, b, p, pe, z;
      int           hs, prev, e;
      logic         inv, byp;
      rst = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; in_state = '0; out_ready = 1'b1;
`ifdef MIX_COLS_SEQ_BYPASS_EN
      in_bypass = 1'b0;
`endif
      #1;
      check(tag("rst_in_ready"), in_ready, 1);
      check(tag("rst_out_valid"), out_valid, 0);
      check(tag("rst_busy"), busy, 0);
      check(tag("rst_out_state"), out_state, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Known forward vector, then the inverse round trip.
      a = {pc(8'hc6, 8'hc6, 8'hc6, 8'hc6), pc(8'h01, 8'h01, 8'h01, 8'h01),
           pc(8'hf2, 8'h0a, 8'h22, 8'h5c), pc(8'hdb, 8'h13, 8'h53, 8'h45)};
      b = {pc(8'hc6, 8'hc6, 8'hc6, 8'hc6), pc(8'h01, 8'h01, 8'h01, 8'h01),
           pc(8'h9f, 8'hdc, 8'h58, 8'h9d), pc(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
      send(a, 1'b0, 1'b0, b, 1'b0, hs);
      send(b, 1'b1, 1'b0, a, 1'b0, hs);
      drain();

      // Backpressure with a competing block held on the input.
      p  = {96'h0, pc(8'hd4, 8'hd4, 8'hd4, 8'hd5)};
      pe = {96'h0, pc(8'hd5, 8'hd5, 8'hd7, 8'hd6)};
      z  = rnd128();
      out_ready = 1'b0;
      send(p, 1'b0, 1'b0, pe, 1'b0, hs);
      in_state = z; in_inverse = 1'b0; in_valid = 1'b1;
      repeat (NG + 10) @(posedge clk);
      #1 out_ready = 1'b1;
      send(z, 1'b0, 1'b0, ref_mix(z, 1'b0), 1'b0, hs);
      drain();

      // Reset while a block is in flight.
      send(rnd128(), 1'b0, 1'b0, '0, 1'b0, hs);
      if (NG > 1) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      #1;
      check(tag("midrst_out_valid"), out_valid, 0);
      check(tag("midrst_out_state"), out_state, 0);
      check(tag("midrst_in_ready"), in_ready, 1);
      check(tag("midrst_busy"), busy, 0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      e = ncyc;
      send({96'h0, pc(8'h2d, 8'h26, 8'h31, 8'h4c)}, 1'b0, 1'b0,
           {96'h0, pc(8'h4d, 8'h7e, 8'hbd, 8'hf8)}, 1'b0, hs);
      check(tag("accept_after_reset"), hs, e + 1);
      drain();

      // Back-to-back random blocks, out_ready tied high.
      prev = -1;
      for (int i = 0; i < 100; i++) begin
        a   = rnd128();
        inv = 1'($urandom_range(0, 1));
        send(a, inv, 1'b0, ref_mix(a, inv), (i < 99), hs);
        if (prev >= 0) check(tag("interval"), hs - prev, NG + 2);
        prev = hs;
      end
      drain();

`ifdef MIX_COLS_SEQ_BYPASS_EN
      for (int i = 0; i < 24; i++) begin
        a   = rnd128();
        inv = 1'($urandom_range(0, 1));
        byp = 1'($urandom_range(0, 1));
        send(a, inv, byp, (byp ? a : ref_mix(a, inv)), 1'b0, hs);
      end
      drain();
`else
      byp = 1'b0;
`endif
      done = 1'b1;
    end
  end

  initial begin : finisher
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (g_inst[0].done && g_inst[1].done && g_inst[2].done) break;
    end
    check("all_instances_done", {g_inst[0].done, g_inst[1].done, g_inst[2].done}, 3'b111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_cols_seq.md
Name: mix_cols_seq

Overview:
- Sequential, parametrised MixColumns/InvMixColumns engine for the round datapath of the iterative AES core.
- Direction is selected per transaction at run time, not by elaboration parameter.
- Processes COLS_PER_CYCLE columns per clock, trading area against latency.
- Uses valid/ready handshakes on both sides so it can sit between the ShiftRows and AddRoundKey stages.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per cycle.
  - Legal values: 1, 2, 4.
  - Any other value is an elaboration-time fatal error.
- NGRP, 4/COLS_PER_CYCLE, localparam: number of compute cycles per block.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_inverse  in  1  0 = MixColumns, 1 = InvMixColumns; sampled on input handshake.
- in_state  in  128  input state.
  - Byte i = in_state[8*i+:8], with i = 4*col + row.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_state  out  128  result state, same byte layout as in_state.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- GF(2^8) arithmetic:
  - Polynomial 0x11B.
  - Forward coefficients {2,3,1,1}, circulant.
  - Inverse coefficients {14,11,13,9}, circulant.
  - Row r of column c uses coefficient (k - r) mod 4 applied to byte a_k.
- Reset values (asynchronous, all registers):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - out_state = 0, group counter = 0, mode register = 0.
- FSM states:
  - IDLE: in_ready = 1.
    - On in_valid & in_ready: capture in_state into the work register, latch in_inverse, set grp = 0, go to BUSY.
  - BUSY: each cycle, columns grp*COLS_PER_CYCLE .. grp*COLS_PER_CYCLE + COLS_PER_CYCLE - 1 of the work register are replaced in place by their transformed values.
    - grp increments each cycle.
    - After grp = NGRP-1 is processed, go to DONE.
  - DONE: out_valid = 1 and out_state = work register.
    - Both are held stable until out_ready.
    - On out_valid & out_ready, go to IDLE.
- Latency:
  - Input handshake edge at cycle T gives out_valid high from cycle T+1+NGRP.
  - This is 5, 3 and 2 cycles for COLS_PER_CYCLE of 1, 2 and 4 respectively.
- Throughput: one block per NGRP+2 cycles when out_ready is tied high.
- in_ready is asserted in IDLE only.
  - in_valid in BUSY or DONE is ignored; the block is not captured.
  - The upstream block must hold until accepted.
- in_inverse and in_state changes after the handshake have no effect on the block in flight.
- out_ready low in DONE is backpressure: no state change, outputs held.
- out_ready high outside DONE is ignored.
- Reset asserted mid-operation:
  - The block in flight is discarded and all outputs return to their reset values immediately.
  - After rst deasserts, the first rising edge may accept a new block.

Optional Feature:
- Macro: MIX_COLS_SEQ_BYPASS_EN.
- When defined:
  - Adds port in_bypass (in, 1), sampled on the input handshake.
  - Bypass blocks are used for the AES final round, which has no MixColumns.
  - A block with in_bypass = 1 goes IDLE -> DONE directly; out_state equals the captured in_state, and out_valid is high at T+1.
  - in_inverse is ignored for bypass blocks.
- When undefined: the port is absent, and every block is transformed with the full NGRP latency.

Decomposition:
- Shared package aes_pkg:
  - mix_fsm_t enum {IDLE, BUSY, DONE}.
  - AES_COLS = 4, AES_POLY = 8'h1B.
  - Automatic functions xtime, gf_mul2/3/9/11/13/14.
  - aes_state_t = logic [127:0].
- Sub-module mix_col_word:
  - Combinational, inputs inverse (1) and col_in (32); output col_out (32).
  - Instantiated COLS_PER_CYCLE times.
  - Column selection is a mux on grp.

Test Plan:
- Forward, COLS_PER_CYCLE = 1, columns (a0..a3):
  - Input: col0 db,13,53,45; col1 f2,0a,22,5c; col2 01,01,01,01; col3 c6,c6,c6,c6.
  - Required out_state: col0 8e,4d,a1,bc; col1 9f,dc,58,9d; col2 01,01,01,01; col3 c6,c6,c6,c6.
  - out_valid must rise exactly 5 cycles after the handshake.
- Inverse round-trip:
  - Feed the previous output with in_inverse = 1.
  - Required: the original input is recovered.
  - Repeat for COLS_PER_CYCLE of 1, 2 and 4; latencies must be 5, 3 and 2.
- Backpressure:
  - Input: forward col0 d4,d4,d4,d5 (other columns zero), with out_ready held low for 10 cycles.
  - Required: out_valid stays high and col0 reads d5,d5,d7,d6 stably; in_ready = 0 throughout.
  - A second in_valid during this period must not be accepted.
- Reset mid-BUSY:
  - Stimulus: assert rst during grp = 1.
  - Required: out_valid = 0, out_state = 0 and in_ready = 1 immediately.
  - The next block (col 2d,26,31,4c) must give 4d,7e,bd,f8.
- Back-to-back with out_ready tied high:
  - Stimulus: 100 random blocks with random modes.
  - Required: all results match the reference model, in order, at one block per NGRP+2 cycles.
- With MIX_COLS_SEQ_BYPASS_EN:
  - Stimulus: in_bypass = 1 with a random state.
  - Required: output equals the input at T+1.
  - Interleaving bypass and non-bypass blocks must keep correct order.
